ssd_scan_ctrl: RTL

Time-multiplexed scan controller for the board's common-anode seven-segment display. It shares a single `SSD` digit decoder among `NUM_DIGITS` digit positions. Each refresh slot it selects one BCD nibble from a frame-buffered shadow register, presents it on `ones` to the decoder, and drives the matching active-low anode after a ghosting dead-time. It sits between the complex-adder result formatting logic (nibble producer) and the `SSD` decoder / board pins.

---
 rtl/ssd_scan_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl: time-multiplexed scan controller for a common-anode 7-seg display.
// Optional feature macro: SSD_LEADING_ZERO_BLANK_EN (dark leading zero digits).
module ssd_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    output logic [3:0]              ones,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic                    frame_done
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int DW = 4 * NUM_DIGITS;

    localparam logic [CW-1:0] C_LAST       = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] C_BLANK_LAST =
        CW'((BLANK_CYCLES > 0) ? (BLANK_CYCLES - 1) : 0);
    localparam logic [IW-1:0] IDX_LAST     = IW'(NUM_DIGITS - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    // Without dead-time the scan never leaves DRIVE, so it also starts there.
    localparam state_t ST_RESET = (BLANK_CYCLES == 0) ? ST_DRIVE : ST_BLANK;

    logic [CW-1:0] c_q, c_d;
    logic [IW-1:0] idx_q, idx_d;
    state_t        state_q, state_d;
    logic [DW-1:0] pending_q, pending_d;
    logic          pending_valid_q, pending_valid_d;
    logic [DW-1:0] shadow_q, shadow_d;

    logic                  c_last;
    logic                  frame_end;
    logic [NUM_DIGITS-1:0] lz_dark;

`ifdef SSD_LEADING_ZERO_BLANK_EN
    logic upper_zero;
`endif

    // Slot prescaler and digit index; both advance together at slot end.
    always_comb begin
        c_last    = (c_q == C_LAST);
        frame_end = c_last && (idx_q == IDX_LAST);
        c_d       = c_last ? '0 : c_q + CW'(1);
        idx_d     = idx_q;
        if (c_last) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end
    end

    // BLANK/DRIVE sequencing within a slot.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_BLANK: begin
                if (c_q == C_BLANK_LAST) begin
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (c_last && (BLANK_CYCLES > 0)) begin
                    state_d = ST_BLANK;
                end
            end
        endcase
    end

    // Double buffer: loads collect in pending, shadow only swaps at frame end.
    always_comb begin
        pending_d       = pending_q;
        pending_valid_d = pending_valid_q;
        shadow_d        = shadow_q;
        if (load) begin
            pending_d       = digits_in;
            pending_valid_d = 1'b1;
        end
        if (frame_end) begin
            if (load) begin
                shadow_d = digits_in;
            end else if (pending_valid_q) begin
                shadow_d = pending_q;
            end
            pending_valid_d = 1'b0;
        end
    end

    // Leading-zero mask, derived from shadow so it is stable for a frame.
    always_comb begin
        lz_dark = '0;
`ifdef SSD_LEADING_ZERO_BLANK_EN
        upper_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            upper_zero = upper_zero && (shadow_q[4*i +: 4] == 4'd0);
            lz_dark[i] = upper_zero;
        end
`endif
    end

    // Digit mux and anode drive; anodes stay off while reset is held.
    always_comb begin
        ones       = 4'd0;
        anode      = '1;
        frame_done = frame_end;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                ones = shadow_q[4*i +: 4];
            end
        end
        if (!rst && (state_q == ST_DRIVE)) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if ((idx_q == IW'(i)) && digit_en[i] && !lz_dark[i]) begin
                    anode[i] = 1'b0;
                end
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            c_q             <= '0;
            idx_q           <= '0;
            state_q         <= ST_RESET;
            pending_q       <= '0;
            pending_valid_q <= 1'b0;
            shadow_q        <= '0;
        end else begin
            c_q             <= c_d;
            idx_q           <= idx_d;
            state_q         <= state_d;
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
            shadow_q        <= shadow_d;
        end
    end

endmodule
